// File: rtl/bmc_tx_pkg.sv
// bmc_tx_pkg: shared types and constants for the BMC transmitter.
package bmc_tx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    TAIL     = 2'd3
  } bmc_state_t;

  localparam int unsigned PREAMBLE_BITS = 64;

  // K-codes, sent as raw 5b symbols, LSB first like every other symbol.
  localparam logic [4:0] K_SYNC1 = 5'b11000;
  localparam logic [4:0] K_SYNC2 = 5'b10001;
  localparam logic [4:0] K_RST1  = 5'b00111;
  localparam logic [4:0] K_RST2  = 5'b11001;
  localparam logic [4:0] K_EOP   = 5'b01101;
  localparam logic [4:0] K_SYNC3 = 5'b00110;

  function automatic logic [4:0] enc_4b5b(input logic [3:0] nib);
    logic [4:0] sym;
    case (nib)
      4'h0:    sym = 5'b11110;
      4'h1:    sym = 5'b01001;
      4'h2:    sym = 5'b10100;
      4'h3:    sym = 5'b10101;
      4'h4:    sym = 5'b01010;
      4'h5:    sym = 5'b01011;
      4'h6:    sym = 5'b01110;
      4'h7:    sym = 5'b01111;
      4'h8:    sym = 5'b10010;
      4'h9:    sym = 5'b10011;
      4'hA:    sym = 5'b10110;
      4'hB:    sym = 5'b10111;
      4'hC:    sym = 5'b11010;
      4'hD:    sym = 5'b11011;
      4'hE:    sym = 5'b11100;
      default: sym = 5'b11101;
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/bmc_tx_ui_tmr.sv
// bmc_tx_ui_tmr: half-UI down-counter. Flags the last clock of the first
// half-UI (o_mid) and the last clock of the full UI (o_ui_end).
module bmc_tx_ui_tmr (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_run,
  input  logic [7:0] i_half,
  output logic       o_mid,
  output logic       o_ui_end
);

  logic [7:0] r_cnt;
  logic       r_phase;
  logic       w_tc;

  assign w_tc     = i_run & (r_cnt == 8'd0);
  assign o_mid    = w_tc & ~r_phase;
  assign o_ui_end = w_tc & r_phase;

  // Count each half-UI down to zero, reload, and flip the half-UI phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (!i_run) begin
      r_cnt   <= i_half;
      r_phase <= 1'b0;
    end else if (w_tc) begin
      r_cnt   <= i_half;
      r_phase <= ~r_phase;
    end else begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

endmodule

// File: rtl/bmc_tx.sv
// bmc_tx: BMC line transmitter -- preamble, 4b5b / raw K-code payload, tail.
// Optional feature macro: BMC_TX_HOLD_LOW_EN. When defined, the tail returns a
// high line to low after one half-UI and holds it low for 4 UI with TX_EN set
// before done; otherwise the tail is a single clock with the line untouched.
//
// The first UI of a frame starts low; every later UI starts with a toggle and
// a 1 bit toggles again at mid-UI.
//
// state    | meaning
// ---------+---------------------------------------------------
// IDLE     | transmitter off, waiting for start
// PREAMBLE | 64 alternating bits, first bit 0
// DATA     | 5b symbols shifted out LSB first
// TAIL     | last symbol finished; closing the frame before done
module bmc_tx
  import bmc_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cfg_half_ui,
  input  logic       start,
  input  logic       in_vld,
  output logic       in_rdy,
  input  logic       in_k,
  input  logic       in_last,
  input  logic [7:0] in_dat,
  output logic       TX_EN,
  output logic       TX_DAT,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  bmc_state_t r_state;
  bmc_state_t w_state_nxt;

  logic [7:0] r_half_ui;
  logic       r_en;
  logic       r_line;
  logic [5:0] r_bit_cnt;
  logic [4:0] r_sym;
  logic [2:0] r_sym_cnt;
  logic       r_buf_vld;
  logic       r_buf_k;
  logic [7:0] r_buf_dat;
  logic       r_hi_pend;
  logic [4:0] r_hi_sym;
  logic       r_last_acc;
`ifdef BMC_TX_HOLD_LOW_EN
  logic [3:0] r_tail_cnt;
`endif

  logic       w_run;
  logic [7:0] w_tmr_half;
  logic       w_mid;
  logic       w_ui_end;
  logic       w_xfer;
  logic       w_load;
  logic       w_have_sym;
  logic       w_finish;
  logic       w_underrun;
  logic       w_done;
  logic       w_tail_done;
  logic       w_cur_bit;
  logic [4:0] w_next_sym;

  assign w_run      = (r_state != IDLE);
  // While idle the timer preloads from the live config so the first half-UI
  // after start already has the right length.
  assign w_tmr_half = (r_state == IDLE) ? cfg_half_ui : r_half_ui;

  bmc_tx_ui_tmr u_ui_tmr (
    .clk      (clk),
    .rst      (rst),
    .i_run    (w_run),
    .i_half   (w_tmr_half),
    .o_mid    (w_mid),
    .o_ui_end (w_ui_end)
  );

  assign in_rdy     = ((r_state == PREAMBLE) || (r_state == DATA)) && !r_buf_vld && !r_last_acc;
  assign w_xfer     = in_vld & in_rdy;
  assign w_cur_bit  = (r_state == PREAMBLE) ? r_bit_cnt[0] : r_sym[0];
  assign w_load     = w_ui_end &
                      (((r_state == PREAMBLE) && (r_bit_cnt == 6'(PREAMBLE_BITS - 1))) ||
                       ((r_state == DATA) && (r_sym_cnt == 3'd4)));
  assign w_have_sym = r_hi_pend | r_buf_vld;
  assign w_finish   = w_load & ~w_have_sym & r_last_acc;

`ifdef BMC_TX_HOLD_LOW_EN
  assign w_tail_done = (w_mid | w_ui_end) & (r_tail_cnt == 4'd1);
`else
  assign w_tail_done = 1'b1;
`endif

  // A pending high-nibble symbol always goes before the buffered element.
  always_comb begin
    w_next_sym = r_hi_sym;
    if (!r_hi_pend) begin
      w_next_sym = r_buf_k ? r_buf_dat[4:0] : enc_4b5b(r_buf_dat[3:0]);
    end
  end

  // Next-state and pulse outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_underrun  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = PREAMBLE;
      end
      PREAMBLE, DATA: begin
        if (w_load) begin
          if (w_have_sym) begin
            w_state_nxt = DATA;
          end else if (r_last_acc) begin
            w_state_nxt = TAIL;
          end else begin
            w_state_nxt = IDLE;
            w_underrun  = 1'b1;
          end
        end
      end
      TAIL: begin
        if (w_tail_done) begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Pulses are suppressed while rst is high so an aborted frame reports nothing.
  assign busy     = (r_state != IDLE);
  assign done     = w_done & ~rst;
  assign underrun = w_underrun & ~rst;
  assign TX_EN    = r_en;
  assign TX_DAT   = r_line;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Element buffer, symbol shifter and line driver.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_half_ui  <= '0;
      r_en       <= 1'b0;
      r_line     <= 1'b0;
      r_bit_cnt  <= '0;
      r_sym      <= '0;
      r_sym_cnt  <= '0;
      r_buf_vld  <= 1'b0;
      r_buf_k    <= 1'b0;
      r_buf_dat  <= '0;
      r_hi_pend  <= 1'b0;
      r_hi_sym   <= '0;
      r_last_acc <= 1'b0;
`ifdef BMC_TX_HOLD_LOW_EN
      r_tail_cnt <= '0;
`endif
    end else begin
      if (w_xfer) begin
        r_buf_vld <= 1'b1;
        r_buf_k   <= in_k;
        r_buf_dat <= in_dat;
        if (in_last) r_last_acc <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (start) begin
            r_half_ui  <= cfg_half_ui;
            r_en       <= 1'b1;
            r_line     <= 1'b0;
            r_bit_cnt  <= '0;
            r_sym_cnt  <= '0;
            r_buf_vld  <= 1'b0;
            r_hi_pend  <= 1'b0;
            r_last_acc <= 1'b0;
          end
        end
        PREAMBLE, DATA: begin
          if (w_mid && w_cur_bit) r_line <= ~r_line;
          if (w_ui_end) begin
            if (w_underrun) begin
              r_en   <= 1'b0;
              r_line <= 1'b0;
            end else if (w_finish) begin
`ifdef BMC_TX_HOLD_LOW_EN
              r_tail_cnt <= r_line ? 4'd9 : 4'd8;
`endif
            end else begin
              r_line <= ~r_line;
              if (w_load) begin
                r_sym     <= w_next_sym;
                r_sym_cnt <= '0;
                if (r_hi_pend) begin
                  r_hi_pend <= 1'b0;
                end else begin
                  r_buf_vld <= 1'b0;
                  if (!r_buf_k) begin
                    r_hi_pend <= 1'b1;
                    r_hi_sym  <= enc_4b5b(r_buf_dat[7:4]);
                  end
                end
              end else if (r_state == PREAMBLE) begin
                r_bit_cnt <= r_bit_cnt + 6'd1;
              end else begin
                r_sym     <= {1'b0, r_sym[4:1]};
                r_sym_cnt <= r_sym_cnt + 3'd1;
              end
            end
          end
        end
        TAIL: begin
`ifdef BMC_TX_HOLD_LOW_EN
          if (w_mid || w_ui_end) begin
            r_line     <= 1'b0;
            r_tail_cnt <= r_tail_cnt - 4'd1;
          end
`endif
          if (w_tail_done) begin
            r_en   <= 1'b0;
            r_line <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bmc_tx.sv
// tb_bmc_tx: randomized frames against a waveform-level reference of the BMC line.
`timescale 1ns/1ps
module tb_bmc_tx;
  import bmc_tx_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cfg_half_ui;
  logic       start;
  logic       in_vld;
  logic       in_rdy;
  logic       in_k;
  logic       in_last;
  logic [7:0] in_dat;
  logic       TX_EN;
  logic       TX_DAT;
  logic       busy;
  logic       done;
  logic       underrun;

  always #5 clk = ~clk;

  bmc_tx dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_half_ui (cfg_half_ui),
    .start       (start),
    .in_vld      (in_vld),
    .in_rdy      (in_rdy),
    .in_k        (in_k),
    .in_last     (in_last),
    .in_dat      (in_dat),
    .TX_EN       (TX_EN),
    .TX_DAT      (TX_DAT),
    .busy        (busy),
    .done        (done),
    .underrun    (underrun)
  );

  int n_chk = 0;
  int n_bad = 0;

  logic [4:0] tbl [16] = '{5'b11110, 5'b01001, 5'b10100, 5'b10101,
                           5'b01010, 5'b01011, 5'b01110, 5'b01111,
                           5'b10010, 5'b10011, 5'b10110, 5'b10111,
                           5'b11010, 5'b11011, 5'b11100, 5'b11101};

  bit         q_k[$];
  logic [7:0] q_dat[$];
  bit         exp_w[$];

  task automatic chk(input string tag, input longint got, input longint want);
    n_chk++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic add_el(input bit k, input logic [7:0] dat);
    q_k.push_back(k);
    q_dat.push_back(dat);
  endtask

  // Expected line level for every clock with TX_EN high, built from the bit list.
  function automatic void build_exp(input int h, input bit complete);
    bit         bits[$];
    logic [4:0] syms[$];
    logic [4:0] s;
    bit         lvl;
    for (int i = 0; i < 64; i++) bits.push_back(i[0]);
    for (int e = 0; e < q_k.size(); e++) begin
      if (q_k[e]) begin
        syms.push_back(q_dat[e][4:0]);
      end else begin
        syms.push_back(tbl[q_dat[e][3:0]]);
        syms.push_back(tbl[q_dat[e][7:4]]);
      end
    end
    foreach (syms[i]) begin
      s = syms[i];
      for (int j = 0; j < 5; j++) bits.push_back(s[j]);
    end
    exp_w.delete();
    lvl = 1'b0;
    foreach (bits[i]) begin
      for (int c = 0; c < h; c++) exp_w.push_back(lvl);
      for (int c = 0; c < h; c++) exp_w.push_back(lvl ^ bits[i]);
      lvl = ~(lvl ^ bits[i]);
    end
    if (complete) begin
`ifdef BMC_TX_HOLD_LOW_EN
      if (!lvl) for (int c = 0; c < h; c++) exp_w.push_back(1'b1);
      for (int c = 0; c < 8 * h; c++) exp_w.push_back(1'b0);
`else
      exp_w.push_back(~lvl);
`endif
    end
  endfunction

  task automatic drive_el(input int idx, input int n, input bit vld_always);
    if (idx < n) begin
      in_k    = q_k[idx];
      in_dat  = q_dat[idx];
      in_last = (idx == n - 1);
      in_vld  = vld_always || ($urandom_range(0, 2) != 0);
    end else begin
      in_k    = 1'b0;
      in_dat  = 8'($urandom);
      in_last = 1'b0;
      in_vld  = vld_always;
    end
  endtask

  task automatic run_frame(input int cfg, input bit vld_always, input bit kick, input bit expect_ur);
    int h, n, idx, cyc, budget, kick_at;
    int xfers, viol, werr, dcnt, didx, ucnt, uidx;
    bit pend, last_acc, fin;
    h = cfg + 1;
    n = q_k.size();
    build_exp(h, !expect_ur);
    budget  = exp_w.size() + 20;
    kick_at = kick ? int'($urandom_range(10, 128 * h - 2)) : -1;
    idx = 0; cyc = 0; xfers = 0; viol = 0; werr = 0;
    dcnt = 0; didx = -1; ucnt = 0; uidx = -1;
    pend = 1'b0; last_acc = 1'b0; fin = 1'b0;
    @(negedge clk);
    cfg_half_ui = 8'(cfg);
    start = 1'b1;
    drive_el(0, n, vld_always);
    while (!fin) begin
      @(negedge clk);
      start = (cyc == kick_at);
      if (pend) begin
        pend = 1'b0;
        idx++;
        drive_el(idx, n, vld_always);
      end else if (!in_vld && idx < n && $urandom_range(0, 2) != 0) begin
        in_vld = 1'b1;
      end
      if (TX_EN !== 1'b1) begin
        fin = 1'b1;
      end else begin
        if (cyc >= exp_w.size() || TX_DAT !== exp_w[cyc]) werr++;
        if (done === 1'b1) begin dcnt++; didx = cyc; end
        if (underrun === 1'b1) begin ucnt++; uidx = cyc; end
        if (last_acc && in_rdy) viol++;
        if (in_vld && in_rdy) begin
          xfers++;
          pend = 1'b1;
          if (in_last) last_acc = 1'b1;
        end
        cyc++;
        if (cyc >= budget) fin = 1'b1;
      end
    end
    start = 1'b0; in_vld = 1'b0; in_last = 1'b0;
    chk("wave_err", werr, 0);
    chk("frame_len", cyc, exp_w.size());
    chk("xfers", xfers, n);
    chk("rdy_after_last", viol, 0);
    chk("busy_after", busy, 0);
    if (expect_ur) begin
      chk("ur_cnt", ucnt, 1);
      chk("ur_idx", uidx, exp_w.size() - 1);
      chk("done_cnt", dcnt, 0);
    end else begin
      chk("done_cnt", dcnt, 1);
      chk("done_idx", didx, exp_w.size() - 1);
      chk("ur_cnt", ucnt, 0);
    end
  endtask

  task automatic chk_all_low(input string tag);
    chk({tag, "_en"},   TX_EN, 0);
    chk({tag, "_dat"},  TX_DAT, 0);
    chk({tag, "_rdy"},  in_rdy, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ur"},   underrun, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_vld = 1'b0; in_k = 1'b0; in_last = 1'b0;
    in_dat = 8'h00; cfg_half_ui = 8'd3;
    repeat (3) @(negedge clk);
    chk_all_low("reset");
    rst = 1'b0;
    in_vld = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_rdy", in_rdy, 0);
    chk("idle_busy", busy, 0);
    chk("idle_en", TX_EN, 0);
    in_vld = 1'b0;

    // Reference frame: SYNC1 x3, SYNC2, 0xA5, EOP(last) at 8 clocks/UI.
    q_k.delete(); q_dat.delete();
    for (int i = 0; i < 3; i++) add_el(1'b1, {3'b000, K_SYNC1});
    add_el(1'b1, {3'b000, K_SYNC2});
    add_el(1'b0, 8'hA5);
    add_el(1'b1, {3'b000, K_EOP});
    run_frame(3, 1'b0, 1'b0, 1'b0);

    // No elements offered: underrun at the preamble end.
    q_k.delete(); q_dat.delete();
    run_frame(2, 1'b0, 1'b0, 1'b1);

    // Reset during preamble bit 30.
    @(negedge clk);
    cfg_half_ui = 8'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30 * 2 * 3 + 1) @(negedge clk);
    chk("rst_pre_en", TX_EN, 1);
    rst = 1'b1;
    #1;
    chk("rst_no_pulse", {done, underrun}, 0);
    @(negedge clk);
    rst = 1'b0;
    chk_all_low("midrst");
    q_k.delete(); q_dat.delete();
    add_el(1'b1, {3'b000, K_RST1});
    add_el(1'b1, {3'b000, K_RST2});
    run_frame(2, 1'b0, 1'b0, 1'b0);

    // Fastest legal UI with in_vld held high throughout.
    q_k.delete(); q_dat.delete();
    add_el(1'b0, 8'h3C);
    add_el(1'b1, {3'b000, K_SYNC3});
    add_el(1'b0, 8'hF0);
    run_frame(1, 1'b1, 1'b0, 1'b0);

    // Random frames with stray start pulses while busy.
    for (int f = 0; f < 8; f++) begin
      int n_el;
      q_k.delete(); q_dat.delete();
      n_el = int'($urandom_range(1, 6));
      for (int e = 0; e < n_el; e++) add_el(1'($urandom_range(0, 1)), 8'($urandom));
      run_frame(int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
